sram_arbiter: RTL and testbench

Two-requester arbiter that shares the single SRAM controller between instruction fetch (IF) and the memory stage (MEM). It sits between the CPU pipeline and the SRAM controller, which provides the `load`/`store`/`stall_req` interface. The arbiter registers each granted request and holds it stable toward the controller until the access completes. It returns read data and per-requester stalls, prioritising MEM with a bounded-starvation guarantee for IF.

---
 rtl/sram_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between instruction fetch and the
// memory stage, MEM first, with a bounded wait for IF.
module sram_arbiter #(
    parameter int IF_STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        sram_load,
    output logic        sram_store,
    output logic [31:0] sram_addr,
    output logic [3:0]  sram_byte_en,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_stall
);

    localparam logic [3:0] STARVE_MAX = IF_STARVE_MAX[3:0];

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_t;

    state_t      state;
    logic [3:0]  starve_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        store_q;

    logic mem_pend;
    logic grant_if;
    logic grant_mem;
    logic busy;

    assign mem_pend = mem_load | mem_store;
    assign busy     = (state != IDLE);

    // MEM wins a tie unless IF has already waited out its allowance
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state == IDLE) begin
            if (mem_pend && !(if_req && starve_cnt == STARVE_MAX)) begin
                grant_mem = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            store_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state   <= BUSY_MEM;
                        addr_q  <= mem_addr;
                        be_q    <= mem_byte_en;
                        wdata_q <= mem_wdata;
                        store_q <= mem_store;
                        if (!if_req) begin
                            starve_cnt <= 4'd0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_if) begin
                        state      <= BUSY_IF;
                        addr_q     <= if_addr;
                        be_q       <= 4'b1111;
                        wdata_q    <= 32'd0;
                        store_q    <= 1'b0;
                        starve_cnt <= 4'd0;
                    end else begin
                        starve_cnt <= 4'd0;
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    if (!sram_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // command held for every busy cycle, dropped by reset without a clock
    assign sram_load    = busy & ~store_q;
    assign sram_store   = busy & store_q;
    assign sram_addr    = addr_q;
    assign sram_byte_en = be_q;
    assign sram_wdata   = wdata_q;

    assign if_rdata  = sram_rdata;
    assign mem_rdata = sram_rdata;

    assign if_stall  = if_req & ~((state == BUSY_IF) & ~sram_stall);
    assign mem_stall = mem_pend & ~((state == BUSY_MEM) & ~sram_stall);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules and a simple controller.
module tb_sram_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        sram_load;
    logic        sram_store;
    logic [31:0] sram_addr;
    logic [3:0]  sram_byte_en;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_stall;

    wire [3:0] ctl = {sram_load, sram_store, if_stall, mem_stall};

    sram_arbiter #(.IF_STARVE_MAX(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_load(mem_load), .mem_store(mem_store),
        .mem_addr(mem_addr), .mem_byte_en(mem_byte_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall),
        .sram_load(sram_load), .sram_store(sram_store),
        .sram_addr(sram_addr), .sram_byte_en(sram_byte_en),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_stall(sram_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference: who owns the controller (0 none, 1 IF, 2 MEM) and what it got
    int          owner;
    int          rem;
    int          m_starve;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_store;
    int          rd_lat = 2;
    int          wr_lat = 3;
    logic [3:0]  e_ctl;

    task automatic model_reset();
        owner    = 0;
        rem      = 0;
        m_starve = 0;
        m_addr   = 32'd0;
        m_wdata  = 32'd0;
        m_be     = 4'd0;
        m_store  = 1'b0;
    endtask

    // drive controller response, form expectations, move to mid-cycle
    task automatic settle(input logic [31:0] rd);
        logic ld;
        logic st;
        logic done;
        sram_stall = (owner != 0) && (rem > 0);
        sram_rdata = rd;
        ld   = (owner == 1) || (owner == 2 && !m_store);
        st   = (owner == 2) && m_store;
        done = (owner != 0) && !sram_stall;
        e_ctl = {ld, st,
                 if_req && !(owner == 1 && done),
                 (mem_load || mem_store) && !(owner == 2 && done)};
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (owner != 0) begin
            if (rem > 0) rem--;
            else owner = 0;
        end else if ((mem_load || mem_store) &&
                     !(if_req && m_starve == MAXS)) begin
            owner   = 2;
            m_addr  = mem_addr;
            m_be    = mem_byte_en;
            m_wdata = mem_wdata;
            m_store = mem_store;
            rem     = mem_store ? wr_lat : rd_lat;
            if (!if_req) m_starve = 0;
            else if (m_starve < MAXS) m_starve++;
        end else if (if_req) begin
            owner    = 1;
            m_addr   = if_addr;
            m_be     = 4'hF;
            m_store  = 1'b0;
            rem      = rd_lat;
            m_starve = 0;
        end else begin
            m_starve = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 0; if_addr = 0;
        mem_load = 0; mem_store = 0;
        mem_addr = 0; mem_byte_en = 0; mem_wdata = 0;
        sram_rdata = 0; sram_stall = 0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (ctl !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000", ctl);
        end
        checks++;
        if ({sram_addr, sram_byte_en, sram_wdata} !== 68'd0) begin
            errors++;
            $display("FAIL reset_latches got %h %h %h want 0",
                     sram_addr, sram_byte_en, sram_wdata);
        end
        if_req = 1; mem_load = 1;
        #1;
        checks++;
        if (ctl !== 4'b0011) begin
            errors++;
            $display("FAIL reset_stall_follow got %b want 0011", ctl);
        end
        if_req = 0; mem_load = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_if_read();
        logic [3:0] want;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                if_req  = 1;
                if_addr = 32'h8000_0010;
            end
            settle(c == 3 ? 32'h1234_5678 : $urandom);
            want = (c == 0) ? 4'b0010 : (c < 3) ? 4'b1010 : 4'b1000;
            checks++;
            if (ctl !== want) begin
                errors++;
                $display("FAIL if_read_ctl c%0d got %b want %b", c, ctl, want);
            end
            if (c > 0) begin
                checks++;
                if ({sram_addr, sram_byte_en} !== {32'h8000_0010, 4'hF}) begin
                    errors++;
                    $display("FAIL if_read_addr c%0d got %h %b want 80000010 1111",
                             c, sram_addr, sram_byte_en);
                end
            end
            if (c == 3) begin
                checks++;
                if (if_rdata !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL if_read_data got %h want 12345678", if_rdata);
                end
            end
            advance();
        end
        if_req = 0;
        settle($urandom);
        checks++;
        if (ctl !== 4'b0000) begin
            errors++;
            $display("FAIL if_read_idle got %b want 0000", ctl);
        end
        advance();
    endtask

    task automatic test_mem_store();
        logic [3:0] want;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                mem_store   = 1;
                mem_addr    = 32'h0000_1000;
                mem_byte_en = 4'b0011;
                mem_wdata   = 32'hCAFE_BABE;
            end
            settle($urandom);
            want = (c == 0) ? 4'b0001 : (c < 4) ? 4'b0101 : 4'b0100;
            checks++;
            if (ctl !== want) begin
                errors++;
                $display("FAIL mem_store_ctl c%0d got %b want %b", c, ctl, want);
            end
            if (c > 0) begin
                checks++;
                if ({sram_addr, sram_byte_en, sram_wdata} !==
                    {32'h0000_1000, 4'b0011, 32'hCAFE_BABE}) begin
                    errors++;
                    $display("FAIL mem_store_latch c%0d got %h %b %h",
                             c, sram_addr, sram_byte_en, sram_wdata);
                end
            end
            advance();
        end
        mem_store = 0;
        settle($urandom);
        advance();
    endtask

    task automatic test_simultaneous();
        logic [3:0] want;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                if_req = 1;   if_addr = 32'h0000_0A00;
                mem_load = 1; mem_addr = 32'h0000_0B00;
                mem_byte_en = 4'b1111;
            end
            if (c == 4) mem_load = 0;
            settle($urandom);
            case (c)
                0:       want = 4'b0011;
                1, 2:    want = 4'b1011;
                3:       want = 4'b1010;
                4:       want = 4'b0010;
                5, 6:    want = 4'b1010;
                default: want = 4'b1000;
            endcase
            checks++;
            if (ctl !== want) begin
                errors++;
                $display("FAIL simul_ctl c%0d got %b want %b", c, ctl, want);
            end
            if (c == 1 || c == 5) begin
                checks++;
                if (sram_addr !== (c == 1 ? 32'h0000_0B00 : 32'h0000_0A00)) begin
                    errors++;
                    $display("FAIL simul_order c%0d got %h", c, sram_addr);
                end
            end
            advance();
        end
        if_req = 0;
        settle($urandom);
        advance();
    endtask

    task automatic test_starvation();
        int   seq[$];
        logic prev;
        int   want;
        rd_lat = 1;
        prev = 0;
        if_req = 1;   if_addr = 32'h0000_0100;
        mem_load = 1; mem_addr = 32'h0000_0200;
        for (int c = 0; c < 40; c++) begin
            settle($urandom);
            if (sram_load && !prev) seq.push_back(sram_addr == 32'h0000_0100 ? 1 : 2);
            prev = sram_load;
            advance();
        end
        checks++;
        if (seq.size() < 10) begin
            errors++;
            $display("FAIL starve_grants got %0d want >=10", seq.size());
        end
        for (int k = 0; k < 10 && k < seq.size(); k++) begin
            want = (k % 5 == 4) ? 1 : 2;
            checks++;
            if (seq[k] != want) begin
                errors++;
                $display("FAIL starve_order k%0d got %0d want %0d", k, seq[k], want);
            end
        end
        if_req = 0; mem_load = 0;
        for (int c = 0; c < 4; c++) begin
            settle($urandom);
            advance();
        end
        rd_lat = 2;
    endtask

    task automatic test_reset_mid();
        mem_store = 1; mem_addr = 32'h0000_3000;
        mem_byte_en = 4'b1100; mem_wdata = 32'h5555_AAAA;
        settle($urandom);
        advance();
        settle($urandom);
        advance();
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ctl !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_ctl got %b want 0001", ctl);
        end
        checks++;
        if ({sram_addr, sram_byte_en, sram_wdata} !== 68'd0) begin
            errors++;
            $display("FAIL rst_mid_latch got %h %b %h want 0",
                     sram_addr, sram_byte_en, sram_wdata);
        end
        mem_store = 0;
        for (int c = 0; c < 2; c++) begin
            settle($urandom);
            advance();
        end
        rst = 1'b1;
        test_if_read();
    endtask

    task automatic test_drop();
        logic [3:0] want;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                if_req = 1; if_addr = 32'h0000_4000;
            end
            if (c == 1) begin
                mem_load = 1; mem_addr = 32'h0000_5000;
                mem_byte_en = 4'b0001;
            end
            if (c == 2) if_req = 0;
            settle($urandom);
            case (c)
                0:          want = 4'b0010;
                1:          want = 4'b1011;
                2, 3:       want = 4'b1001;
                4:          want = 4'b0001;
                5, 6:       want = 4'b1001;
                default:    want = 4'b1000;
            endcase
            checks++;
            if (ctl !== want) begin
                errors++;
                $display("FAIL drop_ctl c%0d got %b want %b", c, ctl, want);
            end
            if (c == 5) begin
                checks++;
                if (sram_addr !== 32'h0000_5000) begin
                    errors++;
                    $display("FAIL drop_next_grant got %h want 00005000", sram_addr);
                end
            end
            advance();
        end
        mem_load = 0;
        settle($urandom);
        advance();
    endtask

    task automatic test_random();
        logic [31:0] rd;
        for (int c = 0; c < 600; c++) begin
            if_req      = ($urandom % 4) != 0;
            if_addr     = $urandom;
            mem_load    = ($urandom % 2) != 0;
            mem_store   = ($urandom % 3) == 0;
            mem_addr    = $urandom;
            mem_byte_en = 4'($urandom);
            mem_wdata   = $urandom;
            rd_lat      = $urandom_range(0, 3);
            wr_lat      = $urandom_range(0, 3);
            rd = $urandom;
            settle(rd);
            checks++;
            if (ctl !== e_ctl) begin
                errors++;
                $display("FAIL rand_ctl c%0d got %b want %b", c, ctl, e_ctl);
            end
            if (owner != 0) begin
                checks++;
                if ({sram_addr, sram_byte_en} !== {m_addr, m_be}) begin
                    errors++;
                    $display("FAIL rand_latch c%0d got %h %b want %h %b",
                             c, sram_addr, sram_byte_en, m_addr, m_be);
                end
            end
            if (owner == 2 && m_store) begin
                checks++;
                if (sram_wdata !== m_wdata) begin
                    errors++;
                    $display("FAIL rand_wdata c%0d got %h want %h",
                             c, sram_wdata, m_wdata);
                end
            end
            if (owner != 0 && rem == 0) begin
                checks++;
                if ((owner == 1 ? if_rdata : mem_rdata) !== rd) begin
                    errors++;
                    $display("FAIL rand_rdata c%0d got %h want %h", c,
                             owner == 1 ? if_rdata : mem_rdata, rd);
                end
            end
            advance();
        end
        if_req = 0; mem_load = 0; mem_store = 0;
        rd_lat = 2; wr_lat = 3;
        for (int c = 0; c < 5; c++) begin
            settle($urandom);
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_store();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
